seq_cla_subtractor: RTL and testbench
=====================================

# seq_cla_subtractor

Multi-cycle subtractor that computes `i_minuend - i_subtrahend` one SLICE-bit chunk per clock, least-significant slice first. Each slice uses carry-lookahead generate/propagate logic on `A + ~B`, and a registered carry is held between slices. The block is the inverse-operation companion to the combinational carry-lookahead adder. It sits behind a valid/ready handshake so wide operands can be handled with a small, fixed slice of lookahead logic. Result format mirrors the adder: `{borrow, difference}`.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be a positive multiple of SLICE.
- `SLICE`, default 8: bits processed per cycle. Sets lookahead width; N = WIDTH/SLICE.
- `i_clk`  input  1  rising-edge clock.
- `i_rst`  input  1  reset; synchronous, active-high.
- `i_valid`  input  1  operands valid.
- `o_ready`  output  1  block can accept operands. High only in IDLE.
- `i_minuend`  input  WIDTH  A operand; sampled on accept.
- `i_subtrahend`  input  WIDTH  B operand; sampled on accept.
- `o_valid`  output  1  result valid. High only in DONE.
- `i_ready`  input  1  downstream accepts result.
- `o_result`  output  WIDTH+1  bit WIDTH = borrow (1 when A < B unsigned); bits WIDTH-1:0 = difference mod 2^WIDTH.

## Operation
- **Method:** A − B = A + ~B + 1. The internal carry register is loaded with 1 on accept. For slice k: Gi = Ai & ~Bi, Pi = Ai | ~Bi, Ci+1 = Gi | (Pi & Ci); slice sum = Ai ^ ~Bi ^ Ci. Borrow = ~carry-out of the final slice.
- **States:** IDLE, RUN, DONE.
  - **IDLE:** o_ready=1. If i_valid, latch A and B into shift registers, set carry=1 and slice counter=0, then go to RUN. Otherwise stay.
  - **RUN:** each cycle, compute the current slice, write it into the result register at `[k*SLICE +: SLICE]`, update carry, and increment the counter. Inputs are ignored. After slice N−1, set borrow = ~carry and go to DONE.
  - **DONE:** o_valid=1 and o_result stable. If i_ready, go to IDLE. Otherwise hold indefinitely.
- **Counter width:** $clog2(N) bits, minimum 1. Compare against N−1; never wrap.
- **Reset:** any state goes to IDLE on the next edge with i_rst=1. Reset values are o_valid=0, o_ready=1 (IDLE), o_result=0, carry=0, counter=0. An operation in progress when reset asserts is discarded with no output.
- **Back-to-back:** no overlap. A new operand is accepted no earlier than the cycle after the DONE→IDLE transition.

## Timing
- **Accept:** at the edge where i_valid & o_ready. That edge is E0.
- **Slices:** computed on edges E1..EN.
- **Result:** o_valid rises after edge EN. Latency from accept to o_valid is N cycles; with SLICE=WIDTH, o_valid is high the cycle after accept.
- **Output release:** the result handshake completes at the first edge with o_valid & i_ready. o_ready is high the following cycle.
- **Throughput:** one result per N+2 cycles with i_ready held high.
- **Output outputs:** all outputs are registered or decoded directly from state. There is no combinational path from i_valid or i_ready to any output.
- **i_rst priority:** i_rst has priority over every handshake in the same cycle.

## Configuration
- **Macro:** `SEQ_SUB_SATURATE_EN`.
- **Defined:** when the final borrow is 1, the difference field o_result[WIDTH-1:0] is forced to 0 in DONE. The borrow bit still reads 1.
- **Undefined:** the difference field is the raw two's-complement wrap value. No saturation logic is present.

## Test plan
- **Basic:** WIDTH=32, SLICE=8, A=0x00000005, B=0x00000003 -> o_valid exactly 4 cycles after accept, o_result=0x0_00000002.
- **Underflow:** A=3, B=5 -> borrow=1, difference=0xFFFFFFFE. With SEQ_SUB_SATURATE_EN: difference=0x00000000, borrow=1.
- **Cross-slice borrow:** A=0x00010000, B=0x00000001 -> o_result=0x0_0000FFFF. A=0, B=0 -> 0x0_00000000. A=0, B=0xFFFFFFFF -> borrow=1, difference=0x00000001.
- **Backpressure:** hold i_ready=0 for 10 cycles in DONE.
  - Required: o_result stable and o_ready=0 throughout.
  - Required: new i_valid ignored until 1 cycle after i_ready=1.
- **Reset mid-operation:** assert i_rst for 1 cycle during RUN slice 2.
  - Required: next cycle o_ready=1, o_valid=0, o_result=0.
  - Required: a fresh operation completes correctly.
- **Degenerate width:** WIDTH=SLICE=8, A=0x10, B=0x20 -> o_valid 1 cycle after accept, o_result=0x1F0. Compare 1000 random pairs against the reference model A−B at WIDTH=32.

Source files
------------

// File: rtl/seq_cla_subtractor.sv
// ---------------------------------------------------------------------------
// seq_cla_subtractor
//
// Multi-cycle unsigned subtractor: computes i_minuend - i_subtrahend one
// SLICE-bit chunk per clock, least-significant slice first, using a
// SLICE-wide carry-lookahead block on A + ~B with a registered carry held
// between slices. Result format is {borrow, difference}.
//
// Parameters:
//   WIDTH - operand width, positive multiple of SLICE
//   SLICE - bits processed per cycle (lookahead width), N = WIDTH/SLICE
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_valid      operands valid
//   o_ready      block can accept operands (high only in IDLE)
//   i_minuend    A operand, sampled on accept
//   i_subtrahend B operand, sampled on accept
//   o_valid      result valid (high only in DONE)
//   i_ready      downstream accepts result
//   o_result     {borrow, difference mod 2^WIDTH}
//
// Optional feature macro: SEQ_SUB_SATURATE_EN
//   When defined, a result with borrow=1 has its difference field forced
//   to zero (borrow bit still reads 1). When undefined, the difference is
//   the raw two's-complement wrap value.
// ---------------------------------------------------------------------------
module seq_cla_subtractor #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH:0]   result_q, result_d;

    // Current slice operands: the shift registers always present the
    // slice being worked on in their low SLICE bits.
    logic [SLICE-1:0] a_sl, nb_sl, gen, prop, sum;
    logic [SLICE:0]   c;
    logic [WIDTH-1:0] a_shift, b_shift;

    assign a_sl  = a_q[SLICE-1:0];
    assign nb_sl = ~b_q[SLICE-1:0];
    assign c[0]  = carry_q;

    genvar gi;
    generate
        for (gi = 0; gi < SLICE; gi++) begin : g_bit
            assign gen[gi]  = a_sl[gi] & nb_sl[gi];
            assign prop[gi] = a_sl[gi] | nb_sl[gi];
            assign sum[gi]  = a_sl[gi] ^ nb_sl[gi] ^ c[gi];

            // Flattened lookahead: every carry is built directly from the
            // slice's generate/propagate terms and the registered carry-in,
            // so no carry ripples through the lower bit positions.
            logic cout;
            always_comb begin
                logic term;
                cout = carry_q;
                for (int k = 0; k <= gi; k++) begin
                    cout = cout & prop[k];
                end
                for (int j = 0; j <= gi; j++) begin
                    term = gen[j];
                    for (int k = j + 1; k <= gi; k++) begin
                        term = term & prop[k];
                    end
                    cout = cout | term;
                end
            end
            assign c[gi+1] = cout;
        end

        if (N > 1) begin : g_shift
            assign a_shift = {{SLICE{1'b0}}, a_q[WIDTH-1:SLICE]};
            assign b_shift = {{SLICE{1'b0}}, b_q[WIDTH-1:SLICE]};
        end else begin : g_noshift
            assign a_shift = '0;
            assign b_shift = '0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    a_d      = i_minuend;
                    b_d      = i_subtrahend;
                    carry_d  = 1'b1;      // the "+1" of A + ~B + 1
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[int'(cnt_q)*SLICE +: SLICE] = sum;
                carry_d = c[SLICE];
                a_d     = a_shift;
                b_d     = b_shift;
                if (cnt_q == LAST_SLICE) begin
                    result_d[WIDTH] = ~c[SLICE];
`ifdef SEQ_SUB_SATURATE_EN
                    if (!c[SLICE]) begin
                        result_d[WIDTH-1:0] = '0;
                    end
`endif
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = (state_q == ST_DONE);
    assign o_result = result_q;

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// ---------------------------------------------------------------------------
// tb_seq_cla_subtractor
//
// Directed-vector bench for seq_cla_subtractor. Two instances share the
// clock and reset: a 32/8 build (four slices) and an 8/8 build (single
// slice). Expected results are hand-computed; the optional saturation
// build (SEQ_SUB_SATURATE_EN) zeroes the difference of borrowing results.
// ---------------------------------------------------------------------------
module tb_seq_cla_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        v32, rdy_in32, ordy32, oval32;
    logic [31:0] a32, b32;
    logic [32:0] res32;

    logic        v8, rdy_in8, ordy8, oval8;
    logic [7:0]  a8, b8;
    logic [8:0]  res8;

    seq_cla_subtractor #(.WIDTH(32), .SLICE(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(ordy32),
        .i_minuend(a32), .i_subtrahend(b32), .o_valid(oval32),
        .i_ready(rdy_in32), .o_result(res32)
    );

    seq_cla_subtractor #(.WIDTH(8), .SLICE(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(ordy8),
        .i_minuend(a8), .i_subtrahend(b8), .o_valid(oval8),
        .i_ready(rdy_in8), .o_result(res8)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] sat33(input logic [32:0] r);
`ifdef SEQ_SUB_SATURATE_EN
        if (r[32]) r[31:0] = '0;
`endif
        return r;
    endfunction

    function automatic logic [8:0] sat9(input logic [8:0] r);
`ifdef SEQ_SUB_SATURATE_EN
        if (r[8]) r[7:0] = '0;
`endif
        return r;
    endfunction

    // Called at a negedge. Waits for o_ready, accepts, then counts edges
    // after the accept edge until o_valid is seen.
    task automatic op32(input logic [31:0] a, input logic [31:0] b,
                        output logic [32:0] res, output int lat);
        int w = 0;
        while (!ordy32 && w < 50) begin @(negedge clk); w++; end
        check("ready32_wait", {63'd0, ordy32}, 64'd1);
        v32 = 1'b1; a32 = a; b32 = b;
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        lat = 0;
        while (!oval32 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        res = res32;
    endtask

    task automatic rel32();
        rdy_in32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_in32 = 1'b0;
        check("ready32_after_release", {63'd0, ordy32}, 64'd1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [8:0] res, output int lat);
        int w = 0;
        while (!ordy8 && w < 50) begin @(negedge clk); w++; end
        check("ready8_wait", {63'd0, ordy8}, 64'd1);
        v8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk);
        @(negedge clk);
        v8 = 1'b0;
        lat = 0;
        while (!oval8 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        res = res8;
        rdy_in8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_in8 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] r;
        logic [32:0] held;
        logic [32:0] exp;
        logic [8:0]  r8;
        int          lat;
        logic [31:0] ra, rb;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 33'h0_0000_0002};
        vecs[1] = '{32'h0000_0003, 32'h0000_0005, 33'h1_FFFF_FFFE};
        vecs[2] = '{32'h0001_0000, 32'h0000_0001, 33'h0_0000_FFFF};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 33'h1_0000_0001};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h0_FFFF_FFFE};
        vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 33'h0_0000_0001};
        vecs[7] = '{32'h1234_5678, 32'h1234_5679, 33'h1_FFFF_FFFF};
        vecs[8] = '{32'h0000_0100, 32'h0000_0001, 33'h0_0000_00FF};

        rst = 1'b1;
        v32 = 1'b0; rdy_in32 = 1'b0; a32 = '0; b32 = '0;
        v8  = 1'b0; rdy_in8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready32",  {63'd0, ordy32}, 64'd1);
        check("rst_valid32",  {63'd0, oval32}, 64'd0);
        check("rst_result32", {31'd0, res32},  64'd0);
        check("rst_ready8",   {63'd0, ordy8},  64'd1);
        check("rst_valid8",   {63'd0, oval8},  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors on the four-slice build
        for (int i = 0; i < 9; i++) begin
            op32(vecs[i].a, vecs[i].b, r, lat);
            exp = sat33(vecs[i].exp);
            $display("vec %0d: a=0x%08h b=0x%08h result=0x%09h latency=%0d", i, vecs[i].a, vecs[i].b, r, lat);
            check("vec_result", {31'd0, r}, {31'd0, exp});
            check("vec_latency", 64'(lat), 64'd4);
            rel32();
        end

        // Backpressure: hold DONE for 10 cycles, offer a new operand meanwhile
        op32(32'h0000_1000, 32'h0000_0001, held, lat);
        check("bp_result", {31'd0, held}, 64'h0_0000_0FFF);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin v32 = 1'b1; a32 = 32'h0000_0007; b32 = 32'h0000_0002; end
            @(posedge clk);
            @(negedge clk);
            check("bp_stable",   {31'd0, res32},  {31'd0, held});
            check("bp_ready_lo", {63'd0, ordy32}, 64'd0);
            check("bp_valid_hi", {63'd0, oval32}, 64'd1);
        end
        rdy_in32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_in32 = 1'b0;
        check("bp_idle_ready", {63'd0, ordy32}, 64'd1);
        check("bp_idle_valid", {63'd0, oval32}, 64'd0);
        @(posedge clk);            // pending i_valid accepted here
        @(negedge clk);
        v32 = 1'b0;
        check("bp_accepted", {63'd0, ordy32}, 64'd0);
        lat = 0;
        while (!oval32 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
        $display("backpressure follow-up: result=0x%09h latency=%0d", res32, lat);
        check("bp_next_latency", 64'(lat), 64'd4);
        check("bp_next_result", {31'd0, res32}, 64'h0_0000_0005);
        rel32();

        // Reset during the third slice
        v32 = 1'b1; a32 = 32'hDEAD_BEEF; b32 = 32'h0000_0001;
        @(posedge clk);            // E0
        @(negedge clk);
        v32 = 1'b0;
        @(posedge clk);            // E1
        @(negedge clk);
        @(posedge clk);            // E2
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);            // E3 sees reset
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-run: ready=%0b valid=%0b result=0x%09h", ordy32, oval32, res32);
        check("midrst_ready",  {63'd0, ordy32}, 64'd1);
        check("midrst_valid",  {63'd0, oval32}, 64'd0);
        check("midrst_result", {31'd0, res32},  64'd0);
        repeat (5) @(negedge clk);
        check("midrst_no_output", {63'd0, oval32}, 64'd0);
        op32(32'hDEAD_BEEF, 32'h0000_BEEF, r, lat);
        $display("post-reset op: result=0x%09h latency=%0d", r, lat);
        check("midrst_fresh_result", {31'd0, r}, 64'h0_DEAD_0000);
        check("midrst_fresh_latency", 64'(lat), 64'd4);
        rel32();

        // Single-slice build
        op8(8'h10, 8'h20, r8, lat);
        $display("w8: a=0x10 b=0x20 result=0x%03h latency=%0d", r8, lat);
        check("w8_under_result", {55'd0, r8}, {55'd0, sat9(9'h1F0)});
        check("w8_latency", 64'(lat), 64'd1);
        op8(8'h20, 8'h10, r8, lat);
        $display("w8: a=0x20 b=0x10 result=0x%03h latency=%0d", r8, lat);
        check("w8_result", {55'd0, r8}, 64'h010);
        op8(8'hFF, 8'hFF, r8, lat);
        $display("w8: a=0xff b=0xff result=0x%03h latency=%0d", r8, lat);
        check("w8_equal", {55'd0, r8}, 64'h000);

        // Random pairs against A - B on a 33-bit reference
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : $urandom;
            if (i % 8 == 1) rb = ra + 32'd1;
            exp = sat33({1'b0, ra} - {1'b0, rb});
            op32(ra, rb, r, lat);
            $display("rand %0d: a=0x%08h b=0x%08h result=0x%09h", i, ra, rb, r);
            check("rand_result", {31'd0, r}, {31'd0, exp});
            rel32();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
